// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants, FSM state type and index helper for the FFT frame loader.
//   N_PTS : samples per frame (the downstream FFT is fixed at 16 points)
//   DW    : bits per real/imaginary component
//   LOG2N : width of a slot index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int N_PTS = 16;
    localparam int DW    = 16;
    localparam int LOG2N = 4;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        CAPTURE = 2'd2
    } fsm_state_t;

    // Reverse the bit order of a slot index (FFT decimation-in-time input order).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = {LOG2N{1'b0}};
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// -----------------------------------------------------------------------------
// fft_frame_loader_if
// Valid/ready sample stream feeding the frame loader.
//   s_valid : upstream has a sample
//   s_ready : loader accepts a sample this cycle
//   s_re    : real part, two's complement
//   s_im    : imaginary part, two's complement
// Modports: master = upstream producer, slave = frame loader.
// -----------------------------------------------------------------------------
interface fft_frame_loader_if;

    logic                  s_valid;
    logic                  s_ready;
    logic [fft_pkg::DW-1:0] s_re;
    logic [fft_pkg::DW-1:0] s_im;

    modport master (
        output s_valid,
        output s_re,
        output s_im,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_re,
        input  s_im,
        output s_ready
    );

endinterface

// File: rtl/fft_frame_regfile.sv
// -----------------------------------------------------------------------------
// fft_frame_regfile
// N_PTS x {re, im} slot store with a single write port and flat read-out.
//   clock, reset : rising-edge clock, synchronous active-high clear
//   we, idx      : write enable and slot index
//   wr_re, wr_im : sample written to slot idx
//   re_flat      : slot k real part at bits [DW*k +: DW]
//   im_flat      : slot k imaginary part, same packing
// Slots not written keep their contents; reset clears every slot.
// -----------------------------------------------------------------------------
module fft_frame_regfile
    import fft_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [LOG2N-1:0]      idx,
    input  logic [DW-1:0]         wr_re,
    input  logic [DW-1:0]         wr_im,
    output logic [N_PTS*DW-1:0]   re_flat,
    output logic [N_PTS*DW-1:0]   im_flat
);

    logic [DW-1:0] re_mem_r [N_PTS];
    logic [DW-1:0] im_mem_r [N_PTS];

    // Slot storage: clear on reset, otherwise single-slot write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PTS; i++) begin
                re_mem_r[i] <= {DW{1'b0}};
                im_mem_r[i] <= {DW{1'b0}};
            end
        end else if (we) begin
            re_mem_r[idx] <= wr_re;
            im_mem_r[idx] <= wr_im;
        end
    end

    // Flatten the registered slots onto the parallel FFT buses.
    for (genvar k = 0; k < N_PTS; k++) begin : g_flat
        assign re_flat[DW*k +: DW] = re_mem_r[k];
        assign im_flat[DW*k +: DW] = im_mem_r[k];
    end

endmodule

// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
// Collects a serial complex sample stream into a 16-point frame, presents it
// on flat buses to the CORDIC FFT, holds it for the FFT latency and pulses
// capture_strobe in the cycle the FFT outputs are valid.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   s              : sample stream (fft_frame_loader_if.slave)
//   xin_flat       : real parts, slot k at [DW*k +: DW], slot 0 = xin1
//   yin_flat       : imaginary parts, same packing
//   frame_valid    : complete, stable frame on the buses (HOLD/CAPTURE)
//   capture_strobe : one-cycle pulse, FFT outputs valid
//   busy           : high in HOLD or CAPTURE
// Parameter FFT_LATENCY (1..255): cycles from frame_valid rise to FFT output.
// Build option FFT_LOADER_BITREV_EN: sample n goes to slot bitrev(n)
// instead of slot n; handshake and timing are unchanged.
// -----------------------------------------------------------------------------
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int FFT_LATENCY = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fft_frame_loader_if.slave    s,
    output logic [N_PTS*DW-1:0]  xin_flat,
    output logic [N_PTS*DW-1:0]  yin_flat,
    output logic                 frame_valid,
    output logic                 capture_strobe,
    output logic                 busy
);

    fsm_state_t       state_r;
    logic [LOG2N-1:0] wr_idx_r;
    logic [7:0]       hold_cnt_r;
    logic             xfer_s;
    logic [LOG2N-1:0] slot_s;

    // Ready depends on state only, so upstream never sees a valid->ready loop.
    assign s.s_ready = (state_r == FILL) && !reset;
    assign xfer_s    = s.s_valid && s.s_ready;

`ifdef FFT_LOADER_BITREV_EN
    assign slot_s = bitrev(wr_idx_r);
`else
    assign slot_s = wr_idx_r;
`endif

    fft_frame_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (xfer_s),
        .idx     (slot_s),
        .wr_re   (s.s_re),
        .wr_im   (s.s_im),
        .re_flat (xin_flat),
        .im_flat (yin_flat)
    );

    // Frame FSM, write index, hold counter and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= FILL;
            wr_idx_r       <= {LOG2N{1'b0}};
            hold_cnt_r     <= 8'd0;
            frame_valid    <= 1'b0;
            capture_strobe <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    capture_strobe <= 1'b0;
                    if (xfer_s) begin
                        // Index is exactly LOG2N bits wide, so the last slot wraps to 0.
                        wr_idx_r <= wr_idx_r + LOG2N'(1);
                        if (wr_idx_r == LOG2N'(N_PTS-1)) begin
                            state_r     <= HOLD;
                            hold_cnt_r  <= 8'd0;
                            frame_valid <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt_r <= hold_cnt_r + 8'd1;
                    if (hold_cnt_r == 8'(FFT_LATENCY-1)) begin
                        state_r        <= CAPTURE;
                        capture_strobe <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_r        <= FILL;
                    hold_cnt_r     <= 8'd0;
                    frame_valid    <= 1'b0;
                    capture_strobe <= 1'b0;
                    busy           <= 1'b0;
                end
                default: begin
                    state_r        <= FILL;
                    wr_idx_r       <= {LOG2N{1'b0}};
                    hold_cnt_r     <= 8'd0;
                    frame_valid    <= 1'b0;
                    capture_strobe <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_loader
// Directed, table-driven bench for fft_frame_loader (FFT_LATENCY = 8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. after the registers of that edge have settled.
// -----------------------------------------------------------------------------
module tb_fft_frame_loader;
    import fft_pkg::*;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            slot;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset;
    logic [N_PTS*DW-1:0] xin_flat;
    logic [N_PTS*DW-1:0] yin_flat;
    logic                frame_valid;
    logic                capture_strobe;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    fft_frame_loader_if bus ();

    fft_frame_loader #(.FFT_LATENCY(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .s              (bus),
        .xin_flat       (xin_flat),
        .yin_flat       (yin_flat),
        .frame_valid    (frame_valid),
        .capture_strobe (capture_strobe),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [N_PTS*DW-1:0] act,
                         input logic [N_PTS*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one beat and keep it stable until it is accepted (bounded wait).
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int waited;
        waited = 0;
        bus.s_valid = 1'b1;
        bus.s_re    = re;
        bus.s_im    = im;
        while (bus.s_ready !== 1'b1 && waited < 64) begin
            step();
            waited++;
        end
        n_checks++;
        if (waited >= 64) begin
            n_fail++;
            $display("FAIL send_timeout: got s_ready=%0b after %0d cycles, required 1", bus.s_ready, waited);
        end
        step();
        bus.s_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the 16th sample: walks the
    // 8 HOLD cycles and the CAPTURE cycle, then checks the return to FILL.
    task automatic hold_check(input string tag, input logic [DW-1:0] slot0);
        for (int c = 1; c <= 9; c++) begin
            check({tag, "_ready_low"}, bus.s_ready, 1'b0);
            check({tag, "_frame_valid"}, frame_valid, 1'b1);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_capture"}, capture_strobe, (c == 9) ? 1'b1 : 1'b0);
            check({tag, "_slot0"}, xin_flat[DW-1:0], slot0);
            step();
        end
        check({tag, "_post_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_post_busy"}, busy, 1'b0);
        check({tag, "_post_capture"}, capture_strobe, 1'b0);
        check({tag, "_post_ready"}, bus.s_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t                vecs[N_PTS];
        int                  slot_map[N_PTS];
        logic [N_PTS*DW-1:0] exp_bus;
        int                  cap_seen;

`ifdef FFT_LOADER_BITREV_EN
        slot_map = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        slot_map = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        for (int n = 0; n < N_PTS; n++) begin
            vecs[n].re   = 16'(n);
            vecs[n].im   = 16'd0 - 16'(n);
            vecs[n].slot = slot_map[n];
        end

        // ---- reset state ----
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_re    = 16'd0;
        bus.s_im    = 16'd0;
        step();
        step();
        check("rst_ready", bus.s_ready, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_capture", capture_strobe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_xin", xin_flat, '0);
        check("rst_yin", yin_flat, '0);
        reset = 1'b0;
        #1;
        check("rst_release_ready", bus.s_ready, 1'b1);

        // ---- basic back-to-back frame ----
        for (int n = 0; n < N_PTS; n++) begin
            send(16'd3200, 16'd0);
            check("basic_fv_timing", frame_valid, (n == N_PTS-1) ? 1'b1 : 1'b0);
        end
        exp_bus = {16{16'd3200}};
        check("basic_xin", xin_flat, exp_bus);
        check("basic_yin", yin_flat, '0);
        hold_check("basic", 16'd3200);

        // ---- gapped input from the vector table ----
        for (int n = 0; n < N_PTS; n++) begin
            step();
            send(vecs[n].re, vecs[n].im);
            check("gap_fv_timing", frame_valid, (n == N_PTS-1) ? 1'b1 : 1'b0);
        end
        for (int n = 0; n < N_PTS; n++) begin
            check("gap_slot_re", xin_flat[DW*vecs[n].slot +: DW], vecs[n].re);
            check("gap_slot_im", yin_flat[DW*vecs[n].slot +: DW], vecs[n].im);
        end

        // ---- backpressure: 17th sample waits through HOLD/CAPTURE ----
        bus.s_valid = 1'b1;
        bus.s_re    = 16'h7FFF;
        bus.s_im    = 16'h1234;
        hold_check("bp", 16'd0);
        step();
        bus.s_valid = 1'b0;
        check("bp_slot0_re", xin_flat[DW-1:0], 16'h7FFF);
        check("bp_slot0_im", yin_flat[DW-1:0], 16'h1234);
        check("bp_busy", busy, 1'b0);
        check("bp_frame_valid", frame_valid, 1'b0);

        // ---- reset mid-fill (7 samples accepted in total) ----
        for (int n = 0; n < 6; n++) begin
            send(16'(200 + n), 16'd5);
        end
        reset = 1'b1;
        #1;
        check("midfill_ready_in_reset", bus.s_ready, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("midfill_xin", xin_flat, '0);
        check("midfill_yin", yin_flat, '0);
        check("midfill_frame_valid", frame_valid, 1'b0);
        check("midfill_ready", bus.s_ready, 1'b1);
        for (int n = 0; n < N_PTS; n++) begin
            send(16'd100, 16'd0);
            check("refill_fv_timing", frame_valid, (n == N_PTS-1) ? 1'b1 : 1'b0);
        end
        exp_bus = {16{16'd100}};
        check("refill_xin", xin_flat, exp_bus);
        check("refill_yin", yin_flat, '0);
        hold_check("refill", 16'd100);

        // ---- reset 3 cycles into HOLD ----
        for (int n = 0; n < N_PTS; n++) begin
            send(16'h0ABC, 16'h0DEF);
        end
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("holdrst_frame_valid", frame_valid, 1'b0);
        check("holdrst_busy", busy, 1'b0);
        check("holdrst_capture", capture_strobe, 1'b0);
        check("holdrst_xin", xin_flat, '0);
        check("holdrst_ready", bus.s_ready, 1'b1);
        cap_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (capture_strobe === 1'b1) cap_seen++;
            step();
        end
        check("holdrst_no_capture", 32'(cap_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
Upstream stage of main_cordic_fft, the 16-point CORDIC FFT.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake.
- Assembles them into one 16-sample frame and drives the FFT's parallel xin1..xin16 / yin1..yin16 inputs as two flat 256-bit buses.
- Holds the frame stable for the FFT's fixed latency, then pulses a capture strobe so downstream logic can sample xout/yout.

Parameters:
- N_PTS, 16, samples per frame; must be a power of two; the FFT is fixed at 16.
- DW, 16, bits per real/imag component.
- FFT_LATENCY, 8, clock cycles from frame_valid rising to FFT outputs being valid; legal range 1..255.

Ports:
- clock, input, 1, single system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- s_valid, input, 1, upstream sample valid.
- s_ready, output, 1, loader can accept a sample this cycle.
- s_re, input, DW, real part of the sample; two's complement.
- s_im, input, DW, imaginary part of the sample; two's complement.
- xin_flat, output, N_PTS*DW, real parts to the FFT; slot k at bits [DW*k+DW-1 : DW*k]; slot 0 maps to xin1.
- yin_flat, output, N_PTS*DW, imaginary parts to the FFT; same packing.
- frame_valid, output, 1, a complete frame is being presented and is stable.
- capture_strobe, output, 1, one-cycle pulse: the FFT outputs are valid this cycle.
- busy, output, 1, high in HOLD or CAPTURE.

Behaviour:
- Reset values:
  - state = FILL, wr_idx = 0, hold_cnt = 0.
  - xin_flat = 0, yin_flat = 0, frame_valid = 0, capture_strobe = 0, busy = 0.
  - s_ready is forced 0 in any cycle where reset is high.
- Handshake:
  - A beat transfers on a rising edge where s_valid && s_ready.
  - s_ready = (state == FILL) && !reset. It is combinational from state only and never depends on s_valid.
  - s_valid gaps are legal; wr_idx advances only on a transfer.
- Storage: on a transfer, {s_re, s_im} is written to slot wr_idx, then wr_idx increments. Unwritten slots keep their previous frame's contents.
- FSM:
  - FILL → HOLD: on the transfer where wr_idx == N_PTS-1. wr_idx wraps to 0. frame_valid rises the next cycle, together with the last slot becoming visible on the buses. hold_cnt is cleared.
  - HOLD: frame_valid = 1, busy = 1, s_ready = 0. hold_cnt increments each cycle. When hold_cnt == FFT_LATENCY-1, go to CAPTURE.
  - CAPTURE (one cycle): capture_strobe = 1, frame_valid = 1, busy = 1. Next state is FILL.
  - On re-entering FILL: frame_valid drops to 0. The buses keep the old frame until they are overwritten slot by slot.
- Latency: capture_strobe asserts exactly FFT_LATENCY+1 cycles after the edge that accepted the 16th sample.
- Back-to-back frames: the first sample of the next frame can be accepted in the cycle after CAPTURE. Minimum frame period is N_PTS + FFT_LATENCY + 1 cycles.
- Simultaneous events: s_valid asserted during HOLD or CAPTURE is ignored. No data is lost, because s_ready = 0 and upstream must hold the beat.
- Reset mid-operation:
  - Reset in any state returns to FILL with wr_idx = 0 and zeroes both buses.
  - A partially filled frame is discarded.
  - A pending capture_strobe is suppressed.
- Arithmetic: no arithmetic on the data. Samples pass bit-exact; no sign extension or scaling.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined: sample n is written to slot bitrev4(n), i.e. the 4-bit index reversed, so the FFT receives bit-reversed input order.
- Undefined: sample n is written to slot n (natural order).
- Handshake and timing are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - N_PTS, DW and LOG2N constants;
  - the fsm_state_t enum {FILL, HOLD, CAPTURE};
  - a bitrev function of width LOG2N.
- One natural sub-module: fft_frame_regfile, the N_PTS×2×DW slot store with write-enable, write index and flat read-out buses.
- The FSM and counters stay in the top module.

Test Plan:
- Basic frame, natural order: after reset, drive 16 back-to-back beats of s_re = 3200, s_im = 0 → next cycle frame_valid = 1, xin_flat = {16{16'd3200}}, yin_flat = 0; capture_strobe high exactly 9 cycles after the 16th accepted edge (FFT_LATENCY = 8); then frame_valid = 0 and s_ready = 1.
- Gapped input: samples n = 0..15 with s_re = n, s_im = -n, and s_valid low on every other cycle → slot k holds re = k, im = 16'hFFFF*k (two's complement of -k); transition to HOLD only after the 16th transfer.
- Backpressure: hold s_valid = 1 with a 17th sample 16'h7FFF throughout HOLD → s_ready = 0 and the sample is not accepted; after CAPTURE it is accepted as slot 0 of the next frame and busy is 0.
- Reset mid-fill: accept 7 samples, assert reset for 1 cycle → buses = 0, wr_idx = 0; then 16 fresh samples of 100 → full frame of 100s and a normal capture_strobe.
- Reset during HOLD, 3 cycles into the hold count → no capture_strobe, frame_valid = 0 the cycle after reset, s_ready = 1 once reset deasserts.
- With FFT_LOADER_BITREV_EN defined: send sample n with value n → slot 8 holds 1, slot 4 holds 2, slot 15 holds 15, slot 0 holds 0.
